// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and small decode helpers. Imported by muldiv_unit and
// available to any controller/decoder that drives the unit.
// ---------------------------------------------------------------------------
package muldiv_pkg;

    // Operation codes as presented on the op port. 3'b110/3'b111 are reserved.
    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] code);
        return (code <= 3'b101);
    endfunction

    // MTHI/MTLO: single-cycle register moves, no datapath iteration.
    function automatic logic op_is_move(input logic [2:0] code);
        return code[2];
    endfunction

    function automatic logic op_is_div(input logic [2:0] code);
        return (code[2:1] == 2'b01);
    endfunction

    // MULT and DIV interpret their operands as two's complement.
    function automatic logic op_is_signed(input logic [2:0] code);
        return !code[2] && code[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// ---------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negate. Used both to take
// operand magnitudes before iterating and to restore result signs after.
//
// Ports:
//   value  [W-1:0]  input operand
//   negate          1 = output -value, 0 = pass value through
//   result [W-1:0]  conditionally negated value
// ---------------------------------------------------------------------------
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ({W{1'b0}} - value) : value;

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative HI/LO multiply/divide unit (MIPS-style). Multiplies use
// shift-add on magnitudes, divides use restoring division on magnitudes;
// a FIX cycle restores signs for MULT/DIV. MTHI/MTLO write HI/LO directly.
//
// A request is captured into a request register at the accepting edge; the
// following edge either performs the move or loads the iteration datapath.
// Operand magnitudes are formed from the request register in that cycle.
//
// Configuration:
//   MULDIV_EARLY_OUT_EN  when defined, multiplies leave CALC as soon as the
//                        remaining multiplier magnitude is exhausted (minimum
//                        one CALC cycle). Divides are fixed-latency always.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request strobe
//   op   [2:0]   operation code (see muldiv_pkg::op_e)
//   a    [W-1:0] multiplicand / dividend / MTHI-MTLO source
//   b    [W-1:0] multiplier / divisor
//   busy         high while a mul/div is iterating or being sign-fixed
//   done         one-cycle pulse: hi/lo hold the new result this cycle
//   hi   [W-1:0] HI register (product upper half / remainder)
//   lo   [W-1:0] LO register (product lower half / quotient)
//   div_by_zero  sticky flag for the last completed divide
// ---------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e             state;

    // Request register: holds the accepted op and operands for the whole
    // operation, so the a/b/op ports are free after acceptance.
    logic               req_valid;
    op_e                req_op;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;

    // Iteration datapath.
    logic [2*WIDTH-1:0] acc;     // mul: running product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand;   // mul: multiplicand, shifted left each cycle
    logic [WIDTH-1:0]   opnd_b;  // mul: multiplier, shifted right; div: divisor, held
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               sign_a;
    logic               sign_b;
    logic               neg_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH:0]     rem_sh;
    logic               fits;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] calc_next;
    logic               calc_last;

    // A mul/div waiting in the request register has committed the unit even
    // though busy is not yet raised, so a second request must not clobber it.
    assign accept = start && !busy && op_is_legal(op)
                    && !(req_valid && !op_is_move(req_op));

    assign sign_a = op_is_signed(req_op) & req_a[WIDTH-1];
    assign sign_b = op_is_signed(req_op) & req_b[WIDTH-1];
    assign neg_q  = sign_a ^ sign_b;

    muldiv_sign_fix #(.W(WIDTH)) u_mag_a (
        .value  (req_a),
        .negate (sign_a),
        .result (mag_a)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_mag_b (
        .value  (req_b),
        .negate (sign_b),
        .result (mag_b)
    );

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .value  (acc),
        .negate (neg_q),
        .result (prod_fix)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
        .value  (acc[WIDTH-1:0]),
        .negate (neg_q),
        .result (quo_fix)
    );

    // Truncating division: remainder takes the sign of the dividend.
    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
        .value  (acc[2*WIDTH-1:WIDTH]),
        .negate (sign_a),
        .result (rem_fix)
    );

    // Restoring-division step: shift the next dividend bit into the partial
    // remainder (one extra bit, since it can reach 2*divisor-1) and subtract
    // the divisor if it fits.
    assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign fits    = (rem_sh >= {1'b0, opnd_b});
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd_b;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        calc_next = acc + (opnd_b[0] ? mcand : {2*WIDTH{1'b0}});
        if (op_is_div(req_op)) begin
            calc_next = fits ? {rem_sub,            acc[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0],  acc[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        calc_last = (cnt == LAST_CNT);
`ifdef MULDIV_EARLY_OUT_EN
        // Multiplier bits above the one consumed this cycle are all zero:
        // the product is complete after this step.
        if (!op_is_div(req_op) && (opnd_b[WIDTH-1:1] == '0)) begin
            calc_last = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too; they are few and
            // this keeps post-reset behaviour fully deterministic.
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            req_valid   <= 1'b0;
            req_op      <= OP_MULTU;
            req_a       <= '0;
            req_b       <= '0;
            acc         <= '0;
            mcand       <= '0;
            opnd_b      <= '0;
            cnt         <= '0;
        end else begin
            done      <= 1'b0;
            req_valid <= accept;

            if (accept) begin
                req_op      <= op_e'(op);
                req_a       <= a;
                req_b       <= b;
                div_by_zero <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (req_valid) begin
                        if (op_is_move(req_op)) begin
                            if (req_op == OP_MTHI) begin
                                hi <= req_a;
                            end else begin
                                lo <= req_a;
                            end
                            done <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            opnd_b <= mag_b;
                            if (op_is_div(req_op)) begin
                                acc   <= {{WIDTH{1'b0}}, mag_a};
                                mcand <= '0;
                            end else begin
                                acc   <= '0;
                                mcand <= {{WIDTH{1'b0}}, mag_a};
                            end
                        end
                    end
                end

                CALC: begin
                    acc <= calc_next;
                    cnt <= cnt + CW'(1);
                    if (!op_is_div(req_op)) begin
                        mcand  <= mcand << 1;
                        opnd_b <= opnd_b >> 1;
                    end
                    if (calc_last) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (op_is_div(req_op)) begin
                        if (req_b == '0) begin
                            lo          <= '1;
                            hi          <= req_a;
                            div_by_zero <= 1'b1;
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32). Directed vectors from a
// table, hand-written sequences for multi-cycle corner cases, then random
// operations checked against a plain-arithmetic reference model.
// Honours MULDIV_EARLY_OUT_EN for expected multiply latency.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W        = 32;
    localparam int LAT_FULL = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_MUL7 = 5;   // multiplier 7: 3 CALC cycles
    localparam int LAT_MUL3 = 4;   // multiplier 3: 2 CALC cycles
`else
    localparam int LAT_MUL7 = LAT_FULL;
    localparam int LAT_MUL3 = LAT_FULL;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_by_zero;

    int            cyc      = 0;
    int            checks   = 0;
    int            failures = 0;
    logic [W-1:0]  m_hi     = '0;
    logic [W-1:0]  m_lo     = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a request for one cycle. Returns at the negedge following the
    // accepting edge T, with t = T. Operands are then scrambled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int t);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        t = cyc;
        start = 1'b0; op = 3'b000; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input int t, output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) begin
                lat = cyc - t;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reference model: results from ordinary integer arithmetic.
    task automatic ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo,
                             output logic [W-1:0] e_hi, output logic [W-1:0] e_lo,
                             output logic e_dbz, output int e_lat);
        logic [63:0] p;
        longint      sx, sy, q, r;
        logic [W-1:0] mag;
        int          nbits;
        e_hi  = cur_hi;
        e_lo  = cur_lo;
        e_dbz = 1'b0;
        e_lat = LAT_FULL;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        case (o)
            3'd0: begin p = {32'd0, x} * {32'd0, y}; {e_hi, e_lo} = p; end
            3'd1: begin q = sx * sy; p = 64'(q); {e_hi, e_lo} = p; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    e_lo = '1; e_hi = x; e_dbz = 1'b1;
                end else if (o == 3'd2) begin
                    e_lo = x / y; e_hi = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    e_lo = q[31:0]; e_hi = r[31:0];
                end
            end
            3'd4: begin e_hi = x; e_lat = 1; end
            3'd5: begin e_lo = x; e_lat = 1; end
            default: ;
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (o <= 3'd1) begin
            mag = (o == 3'd1 && y[W-1]) ? -y : y;
            nbits = 0;
            for (int i = 0; i < W; i++) if (mag[i]) nbits = i + 1;
            e_lat = ((nbits < 1) ? 1 : nbits) + 2;
        end
`endif
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                          input logic e_dbz, input int e_lat);
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;
        bit           busy_ok;
        bit           hold_ok;
        int           t;
        int           lat;
        hi0 = hi; lo0 = lo; busy_ok = 1'b1; hold_ok = 1'b1; lat = -1;
        issue(o, x, y, t);
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) begin
                lat = cyc - t;
                break;
            end
            if (busy !== (cyc > t)) busy_ok = 1'b0;
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(lat), 64'(e_lat));
        check({name, "_busy_window"}, 64'(busy_ok), 64'd1);
        check({name, "_hilo_hold"}, 64'(hold_ok), 64'd1);
        check({name, "_hi"}, 64'(hi), 64'(e_hi));
        check({name, "_lo"}, 64'(lo), 64'(e_lo));
        check({name, "_dbz"}, 64'(div_by_zero), 64'(e_dbz));
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    initial begin
        int           t, t2, lat, cnt_a, cnt_b;
        logic [W-1:0] hi0, lo0, x, y, e_hi, e_lo;
        logic         e_dbz;
        logic [2:0]   o;
        int           e_lat;

        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        check("reset_dbz",  64'(div_by_zero), 64'd0);
        rst = 1'b0;

        //            op        a             b             hi            lo            dbz   lat
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT_FULL};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LAT_MUL7};
        vecs[2]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, LAT_FULL};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_FULL};
        vecs[4]  = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, LAT_FULL};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT_FULL};
        vecs[6]  = '{OP_MULTU, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F, 1'b0, LAT_MUL3};
        vecs[7]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0, LAT_FULL};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT_FULL};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, LAT_FULL};
        vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, LAT_FULL};

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
        end

        // MTHI then MTLO on consecutive edges: two done pulses, busy stays low.
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h1234; b = '0;
        @(negedge clk);
        check("mt_no_done_yet", 64'(done), 64'd0);
        op = OP_MTLO; a = 32'h5678;
        @(negedge clk);
        start = 1'b0; op = 3'b000; a = '0;
        check("mthi_done", 64'(done), 64'd1);
        check("mthi_hi",   64'(hi),   64'h1234);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_clears_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        check("mtlo_done", 64'(done), 64'd1);
        check("mtlo_lo",   64'(lo),   64'h5678);
        check("mtlo_hi",   64'(hi),   64'h1234);
        @(negedge clk);
        check("mt_done_ends", 64'(done), 64'd0);
        m_hi = 32'h1234; m_lo = 32'h5678;

        // start with new operands at busy cycle 5 is ignored.
        issue(OP_MULTU, 32'h6, 32'h80000007, t);
        repeat (5) @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        wait_done(t, lat);
        check("ignore_latency", 64'(lat), 64'(LAT_FULL));
        check("ignore_hi", 64'(hi), 64'h3);
        check("ignore_lo", 64'(lo), 64'h2A);
        @(negedge clk);
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) cnt_a++;
            @(negedge clk);
        end
        check("ignore_no_second_op", 64'(cnt_a), 64'd0);

        // New request accepted in the DONE cycle.
        issue(OP_MULTU, 32'h2, 32'h80000001, t);
        wait_done(t, lat);
        check("chain_first_latency", 64'(lat), 64'(LAT_FULL));
        check("chain_first_hi", 64'(hi), 64'h1);
        check("chain_first_lo", 64'(lo), 64'h2);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        t2 = cyc;
        start = 1'b0; op = 3'b000; a = '0; b = '0;
        wait_done(t2, lat);
        check("chain_second_latency", 64'(lat), 64'(LAT_FULL));
        check("chain_second_lo", 64'(lo), 64'd14);
        check("chain_second_hi", 64'(hi), 64'd2);
        @(negedge clk);

        // Reserved ops: no state change, no done.
        hi0 = hi; lo0 = lo; cnt_a = 0; cnt_b = 0;
        for (int code = 6; code < 8; code++) begin
            @(negedge clk);
            start = 1'b1; op = 3'(code); a = $urandom; b = $urandom;
        end
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1 || busy === 1'b1) cnt_a++;
            if (hi !== hi0 || lo !== lo0) cnt_b++;
            @(negedge clk);
        end
        check("reserved_no_activity", 64'(cnt_a), 64'd0);
        check("reserved_hilo_kept", 64'(cnt_b), 64'd0);

        // Reset at CALC cycle 10 aborts immediately with no done pulse.
        issue(OP_DIV, 32'd1000, 32'd3, t);
        repeat (10) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 50; k++) begin
            if (done === 1'b1 || busy === 1'b1) cnt_a++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(cnt_a), 64'd0);
        m_hi = '0; m_lo = '0;

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1:       y = 32'($urandom_range(0, 15));
                2:       y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            ref_model(o, x, y, m_hi, m_lo, e_hi, e_lo, e_dbz, e_lat);
            run_op($sformatf("rand%0d_op%0d", i, o), o, x, y, e_hi, e_lo, e_dbz, e_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width; legal values are even and >=4.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; reset is asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request strobe, sampled on each clk edge.
REQ-005 SHALL have port op  input  3  operation code: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-006 SHALL have port a  input  WIDTH  multiplicand/dividend/MTHI/MTLO source.
REQ-007 SHALL have port b  input  WIDTH  multiplier/divisor.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking the cycle in which hi/lo first hold the new result.
REQ-010 SHALL have port hi  output  WIDTH  HI register: product upper half or remainder.
REQ-011 SHALL have port lo  output  WIDTH  LO register: product lower half or quotient.
REQ-012 SHALL have port div_by_zero  output  1  sticky flag for the last completed divide; cleared by the next accepted op.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL accept a request when start=1, busy=0 and op is not reserved, latching a, b and op at that edge; a, b and op are don't-care afterwards.
REQ-015 SHALL ignore start while busy=1, and SHALL ignore reserved ops at any time (no state change, no done).
REQ-016 SHALL, for MTHI/MTLO accepted at edge T, update hi or lo at edge T+1 and pulse done in cycle T+1, with busy staying 0.
REQ-017 SHALL, for mul/div accepted at edge T, drive busy=1 from T+1 to T+WIDTH+1 inclusive, spend CALC at T+1..T+WIDTH, spend FIX at T+WIDTH+1, and update hi/lo with done=1 and busy=0 at T+WIDTH+2.
REQ-018 SHALL accept a new request in the DONE cycle.
REQ-019 SHALL multiply by shift-add on operand magnitudes into a 2*WIDTH accumulator, one multiplier bit per CALC cycle, with multiplicand shifted left each cycle.
REQ-020 SHALL divide by restoring division on operand magnitudes, one quotient bit per CALC cycle.
REQ-021 SHALL, in FIX for signed ops, negate the product when sign(a) XOR sign(b); negate the quotient on sign mismatch; and give the remainder the sign of a (truncating division).
REQ-022 SHALL, for divide with b=0, produce lo=all ones, hi=a unchanged and div_by_zero=1, with the same latency as other divides.
REQ-023 SHALL, for DIV of most-negative by -1, produce lo=most-negative and hi=0, with no flag.
REQ-024 SHALL keep hi/lo unchanged from acceptance until the DONE edge.

Reset
REQ-025 SHALL, while rst is high, force state=IDLE and busy=0, done=0, hi=0, lo=0, div_by_zero=0 immediately, including mid-operation.
REQ-026 SHALL abort any in-flight operation on reset without producing a done pulse.

Configuration
REQ-027 SHALL, with MULDIV_EARLY_OUT_EN defined, have multiplies leave CALC for FIX after the first CALC cycle in which the remaining unshifted multiplier magnitude is zero, with a minimum of 1 CALC cycle, and produce identical results.
REQ-028 SHALL, without MULDIV_EARLY_OUT_EN, use fixed WIDTH-cycle CALC for all mul/div, and divides SHALL be fixed-latency in both builds.

Structure
REQ-029 SHALL take op encodings and the FSM state type from shared package muldiv_pkg, for reuse by controller/decoder.
REQ-030 SHALL be a single module; an optional sub-module muldiv_sign_fix (combinational magnitude/negate helper) is permitted, with no other hierarchy.

Verification (WIDTH=32, macro off unless stated)
REQ-031 SHALL check: MULTU a=0xFFFFFFFF b=0xFFFFFFFF at T -> hi=0xFFFFFFFE, lo=0x00000001, done exactly at T+34.
REQ-032 SHALL check: MULT a=0xFFFFFFFD b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIVU 7/2 -> lo=3, hi=1; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL check: DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1; next DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-034 SHALL check: start with new operands at busy cycle 5 -> ignored, first result returned; rst at CALC cycle 10 -> busy=0, hi=lo=0, no done pulse.
REQ-035 SHALL check: MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, two done pulses.
REQ-036 SHALL check, macro on: MULTU 5*3 at T -> lo=15, hi=0, done at T+4; MULTU 0xFFFFFFFF*0x80000000 -> done at T+34 with a result identical to the macro-off build.
